// File: rtl/lcd_timing_gen.sv
// LCD panel timing generator: pixel/line counters, active-area coordinates,
// frame strobes and polarity-adjusted HSYNC/VSYNC/DATA_EN behind a PIPE-stage delay.
//
// state | meaning
// IDLE  | counters parked at 0, all outputs inactive, waiting for run
// SCAN  | counters sweep the frame; a frame always completes once started
module lcd_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int PIPE     = 1,
  parameter int CW       = 11
) (
  input  logic          P_CLK,
  input  logic          NRST,
  input  logic          run,
  output logic          busy,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          pix_act,
  output logic          line_start,
  output logic          frame_start,
  output logic          active_end,
  output logic [15:0]   frame_cnt,
  output logic          HSYNC,
  output logic          VSYNC,
  output logic          DATA_EN
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SYNC_E = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SYNC_E = CW'(V_SYNC);
  localparam logic [CW-1:0] H_ACT_B  = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] H_ACT_E  = CW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_B  = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] V_ACT_E  = CW'(V_SYNC + V_BP + V_ACTIVE);

  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state_q;
  logic [CW-1:0] h_cnt_q;
  logic [CW-1:0] v_cnt_q;
  logic [15:0]   frame_cnt_q;

  logic scan;
  logic h_in;
  logic v_in;
  logic hs_raw;
  logic vs_raw;
  logic hs_lvl;
  logic vs_lvl;

  always_ff @(posedge P_CLK or negedge NRST) begin
    if (!NRST) begin
      state_q     <= IDLE;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          h_cnt_q <= '0;
          v_cnt_q <= '0;
          if (run) state_q <= SCAN;
        end
        SCAN: begin
          if (frame_start) frame_cnt_q <= frame_cnt_q + 16'd1;
          if (h_cnt_q == H_LAST) begin
            h_cnt_q <= '0;
            if (v_cnt_q == V_LAST) begin
              // run is only sampled at the frame boundary so a frame is never cut short
              v_cnt_q <= '0;
              if (!run) state_q <= IDLE;
            end else begin
              v_cnt_q <= v_cnt_q + 1'b1;
            end
          end else begin
            h_cnt_q <= h_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    scan        = (state_q == SCAN);
    h_in        = (h_cnt_q >= H_ACT_B) && (h_cnt_q < H_ACT_E);
    v_in        = (v_cnt_q >= V_ACT_B) && (v_cnt_q < V_ACT_E);
    pix_act     = scan && h_in && v_in;
    pix_x       = pix_act ? (h_cnt_q - H_ACT_B) : '0;
    pix_y       = pix_act ? (v_cnt_q - V_ACT_B) : '0;
    hs_raw      = scan && (h_cnt_q < H_SYNC_E);
    vs_raw      = scan && (v_cnt_q < V_SYNC_E);
    line_start  = scan && (h_cnt_q == '0);
    frame_start = line_start && (v_cnt_q == '0);
    active_end  = line_start && (v_cnt_q == V_ACT_E);
    hs_lvl      = hs_raw ? HS_ON : ~HS_ON;
    vs_lvl      = vs_raw ? VS_ON : ~VS_ON;
  end

  assign busy      = scan;
  assign frame_cnt = frame_cnt_q;

  // Panel signals are delayed together so they stay aligned with downstream pixel data.
  if (PIPE == 0) begin : g_nopipe
    assign HSYNC   = hs_lvl;
    assign VSYNC   = vs_lvl;
    assign DATA_EN = pix_act;
  end else begin : g_pipe
    logic [PIPE-1:0] hs_sr_q;
    logic [PIPE-1:0] vs_sr_q;
    logic [PIPE-1:0] de_sr_q;

    always_ff @(posedge P_CLK or negedge NRST) begin
      if (!NRST) begin
        hs_sr_q <= {PIPE{~HS_ON}};
        vs_sr_q <= {PIPE{~VS_ON}};
        de_sr_q <= '0;
      end else begin
        hs_sr_q[0] <= hs_lvl;
        vs_sr_q[0] <= vs_lvl;
        de_sr_q[0] <= pix_act;
        for (int i = 1; i < PIPE; i++) begin
          hs_sr_q[i] <= hs_sr_q[i-1];
          vs_sr_q[i] <= vs_sr_q[i-1];
          de_sr_q[i] <= de_sr_q[i-1];
        end
      end
    end

    assign HSYNC   = hs_sr_q[PIPE-1];
    assign VSYNC   = vs_sr_q[PIPE-1];
    assign DATA_EN = de_sr_q[PIPE-1];
  end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Scoreboard bench for lcd_timing_gen on a small 15x8 raster (PIPE=2 and a PIPE=0 twin).
// Expected events are queued per cycle when a scan is launched; a negedge monitor matches them.
module tb_lcd_timing_gen;

  localparam int CW = 11;

  logic          clk;
  logic          nrst;
  logic          run;
  logic          busy;
  logic [CW-1:0] pix_x;
  logic [CW-1:0] pix_y;
  logic          pix_act;
  logic          line_start;
  logic          frame_start;
  logic          active_end;
  logic [15:0]   frame_cnt;
  logic          hsync;
  logic          vsync;
  logic          data_en;

  logic          z_busy;
  logic [CW-1:0] z_pix_x;
  logic [CW-1:0] z_pix_y;
  logic          z_pix_act;
  logic          z_line_start;
  logic          z_frame_start;
  logic          z_active_end;
  logic [15:0]   z_frame_cnt;
  logic          z_hsync;
  logic          z_vsync;
  logic          z_data_en;

  lcd_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .PIPE(2), .CW(CW)
  ) dut (
    .P_CLK(clk), .NRST(nrst), .run(run), .busy(busy),
    .pix_x(pix_x), .pix_y(pix_y), .pix_act(pix_act),
    .line_start(line_start), .frame_start(frame_start), .active_end(active_end),
    .frame_cnt(frame_cnt), .HSYNC(hsync), .VSYNC(vsync), .DATA_EN(data_en)
  );

  lcd_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .PIPE(0), .CW(CW)
  ) dut0 (
    .P_CLK(clk), .NRST(nrst), .run(run), .busy(z_busy),
    .pix_x(z_pix_x), .pix_y(z_pix_y), .pix_act(z_pix_act),
    .line_start(z_line_start), .frame_start(z_frame_start), .active_end(z_active_end),
    .frame_cnt(z_frame_cnt), .HSYNC(z_hsync), .VSYNC(z_vsync), .DATA_EN(z_data_en)
  );

  typedef struct {
    int cyc;
    int kind;
    int a;
    int b;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  nvec = 0;
  int  nfail = 0;
  int  exp_fcnt = 0;
  bit  mon_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic string kname(input int k);
    case (k)
      0: return "frame_start";
      1: return "line_start";
      2: return "active_end";
      3: return "pix_act";
      4: return "DATA_EN";
      5: return "HSYNC_low";
      6: return "VSYNC_low";
      7: return "busy";
      default: return "DATA_EN_pipe0";
    endcase
  endfunction

  task automatic push(input int c, input int k, input int a, input int b);
    ev_t e;
    e.cyc = c; e.kind = k; e.a = a; e.b = b;
    q.push_back(e);
  endtask

  // Hand-derived raster for H 3/2/8/2 (total 15) and V 2/1/4/1 (total 8):
  // active h 5..12, active v 3..6, active_end on line 7, panel outputs 2 cycles late.
  task automatic push_scan(input int s, input int nfr, input int c_stop);
    for (int c = s; c <= c_stop; c++) begin
      int t, td, h, v, hd, vd;
      bit sc, scd, pixn, pixd;
      t    = c - s;
      td   = c - 2 - s;
      sc   = (t < 120 * nfr);
      scd  = (td >= 0) && (td < 120 * nfr);
      h    = t % 15;
      v    = (t / 15) % 8;
      hd   = scd ? td % 15 : 0;
      vd   = scd ? (td / 15) % 8 : 0;
      pixn = sc && h >= 5 && h <= 12 && v >= 3 && v <= 6;
      pixd = scd && hd >= 5 && hd <= 12 && vd >= 3 && vd <= 6;
      if (sc && h == 0 && v == 0) begin
        push(c, 0, exp_fcnt, 0);
        exp_fcnt++;
      end
      if (sc && h == 0) push(c, 1, 0, 0);
      if (sc && h == 0 && v == 7) push(c, 2, 0, 0);
      if (pixn) push(c, 3, h - 5, v - 3);
      if (pixd) push(c, 4, 0, 0);
      if (scd && hd < 3) push(c, 5, 0, 0);
      if (scd && vd < 2) push(c, 6, 0, 0);
      if (sc) push(c, 7, 0, 0);
      if (pixn) push(c, 8, 0, 0);
    end
  endtask

  always @(negedge clk) if (mon_en) begin : mon
    logic [8:0] obs;
    obs = {z_data_en, busy, ~vsync, ~hsync, data_en, pix_act, active_end, line_start, frame_start};
    while (q.size() > 0 && q[0].cyc < cyc) begin
      nvec++;
      nfail++;
      $display("FAIL %s cycle %0d: observed 0, required 1", kname(q[0].kind), q[0].cyc);
      void'(q.pop_front());
    end
    for (int k = 0; k < 9; k++) begin
      bit ex;
      ex = (q.size() > 0) && (q[0].cyc == cyc) && (q[0].kind == k);
      if (obs[k] || ex) begin
        nvec++;
        if (obs[k] && ex) begin
          if (k == 0 && int'(frame_cnt) != q[0].a) begin
            nfail++;
            $display("FAIL frame_cnt cycle %0d: observed %0d, required %0d", cyc, frame_cnt, q[0].a);
          end else if (k == 3 && (int'(pix_x) != q[0].a || int'(pix_y) != q[0].b)) begin
            nfail++;
            $display("FAIL pix_xy cycle %0d: observed (%0d,%0d), required (%0d,%0d)",
                     cyc, pix_x, pix_y, q[0].a, q[0].b);
          end
          void'(q.pop_front());
        end else if (obs[k]) begin
          nfail++;
          $display("FAIL %s cycle %0d: observed 1, required 0", kname(k), cyc);
        end else begin
          nfail++;
          $display("FAIL %s cycle %0d: observed 0, required 1", kname(k), cyc);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    nvec++;
    if (act != req) begin
      nfail++;
      $display("FAIL %s cycle %0d: observed %0d, required %0d", nm, cyc, act, req);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    int s;
    nrst = 1'b0;
    run  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_hsync", int'(hsync), 1);
    chk("reset_vsync", int'(vsync), 1);
    chk("reset_data_en", int'(data_en), 0);
    chk("reset_frame_cnt", int'(frame_cnt), 0);
    nrst = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);

    // Two back-to-back frames, run dropped during the second.
    run = 1'b1;
    s = cyc + 1;
    push_scan(s, 2, s + 241);
    wait_to(s);
    chk("first_frame_start", int'(frame_start), 1);
    chk("first_busy", int'(busy), 1);
    wait_to(s + 50);
    chk("first_pix_act", int'(pix_act), 1);
    chk("first_pix_x", int'(pix_x), 0);
    chk("first_pix_y", int'(pix_y), 0);
    wait_to(s + 52);
    chk("first_data_en", int'(data_en), 1);
    wait_to(s + 102);
    chk("last_pix_x", int'(pix_x), 7);
    chk("last_pix_y", int'(pix_y), 3);
    wait_to(s + 120);
    chk("second_frame_start", int'(frame_start), 1);
    chk("second_frame_cnt", int'(frame_cnt), 1);
    wait_to(s + 130);
    run = 1'b0;
    wait_to(s + 239);
    chk("busy_last_cycle", int'(busy), 1);
    wait_to(s + 240);
    chk("busy_after_end", int'(busy), 0);
    wait_to(s + 242);
    chk("frame_cnt_two", int'(frame_cnt), 2);
    chk("idle_hsync", int'(hsync), 1);
    chk("idle_data_en", int'(data_en), 0);

    // Run dropped at v=2: the frame still completes, no further frame.
    wait_to(s + 245);
    run = 1'b1;
    s = cyc + 1;
    push_scan(s, 1, s + 121);
    wait_to(s + 30);
    run = 1'b0;
    wait_to(s + 119);
    chk("drop_busy_end", int'(busy), 1);
    wait_to(s + 120);
    chk("drop_busy_low", int'(busy), 0);
    wait_to(s + 125);
    chk("frame_cnt_three", int'(frame_cnt), 3);

    // Reset pulsed at v=4, h=6 abandons the frame; restart only via run.
    wait_to(s + 130);
    run = 1'b1;
    s = cyc + 1;
    push_scan(s, 1, s + 66);
    wait_to(s + 66);
    #1;
    nrst = 1'b0;
    run  = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_pix_act", int'(pix_act), 0);
    chk("rst_pix_x", int'(pix_x), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    chk("rst_hsync", int'(hsync), 1);
    chk("rst_vsync", int'(vsync), 1);
    chk("rst_data_en", int'(data_en), 0);
    chk("rst_line_start", int'(line_start), 0);
    exp_fcnt = 0;
    wait_to(s + 68);
    #1;
    nrst = 1'b1;
    wait_to(s + 72);
    chk("no_self_restart", int'(busy), 0);
    run = 1'b1;
    s = cyc + 1;
    push_scan(s, 1, s + 121);
    wait_to(s);
    chk("restart_frame_start", int'(frame_start), 1);
    chk("restart_frame_cnt", int'(frame_cnt), 0);
    wait_to(s + 5);
    run = 1'b0;
    wait_to(s + 125);
    chk("restart_frame_cnt_end", int'(frame_cnt), 1);
    chk("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/lcd_timing_gen.md
LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 800, active pixels per line.
REQ-002 SHALL have parameters H_FP / H_SYNC / H_BP, defaults 40 / 128 / 88, horizontal front porch / sync / back porch in pixels, each >=1.
REQ-003 SHALL have parameter V_ACTIVE, default 480, active lines per frame.
REQ-004 SHALL have parameters V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical porches and sync in lines, each >=1.
REQ-005 SHALL have parameters HS_POL / VS_POL, default 0, sync asserted level (0 = active-low).
REQ-006 SHALL have parameter PIPE, default 1, range 0..7, delay in cycles from pix_* to HSYNC/VSYNC/DATA_EN.
REQ-007 SHALL have parameter CW, default 11, width of counters and coordinates; H_TOTAL and V_TOTAL SHALL fit in CW bits.
REQ-008 P_CLK  in  1  pixel clock; all logic on its rising edge.
REQ-009 NRST  in  1  reset, asynchronous assert, active-low.
REQ-010 run  in  1  level request to scan frames.
REQ-011 busy  out  1  high while a frame is in progress.
REQ-012 pix_x / pix_y  out  CW  active-area coordinate of the current counter position; 0 when outside the active area.
REQ-013 pix_act  out  1  counter position lies inside the active area.
REQ-014 line_start / frame_start / active_end  out  1  single-cycle strobes.
REQ-015 frame_cnt  out  16  completed-frame-start count.
REQ-016 HSYNC / VSYNC / DATA_EN  out  1  panel timing, delayed PIPE cycles.

Function
REQ-017 Derived totals SHALL be H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP and V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP.
REQ-018 Line order SHALL be sync, back porch, active, front porch; frame order SHALL be the same in lines.
REQ-019 Registered counters SHALL be h_cnt in 0..H_TOTAL-1 and v_cnt in 0..V_TOTAL-1; h_cnt SHALL wrap to 0 after H_TOTAL-1 and advance v_cnt; v_cnt SHALL wrap to 0 after V_TOTAL-1.
REQ-020 FSM SHALL have states IDLE and SCAN.
REQ-021 In IDLE, counters SHALL hold 0, busy=0, and all strobes, pix_act and sync (deasserted level) SHALL be inactive.
REQ-022 IDLE->SCAN SHALL occur on the first rising edge with run=1; the next cycle SHALL show h_cnt=0, v_cnt=0, busy=1.
REQ-023 In SCAN, run=0 SHALL NOT abort the frame; at h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1 with run=0 the FSM SHALL enter IDLE; with run=1 it SHALL continue into the next frame with no gap cycle.
REQ-024 In SCAN, raw hsync SHALL be asserted iff h_cnt < H_SYNC, and raw vsync SHALL be asserted iff v_cnt < V_SYNC.
REQ-025 pix_act SHALL be high iff H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACTIVE and V_SYNC+V_BP <= v_cnt < V_SYNC+V_BP+V_ACTIVE.
REQ-026 pix_x SHALL be h_cnt-(H_SYNC+H_BP) and pix_y SHALL be v_cnt-(V_SYNC+V_BP) when pix_act=1, and 0 otherwise.
REQ-027 In SCAN, line_start SHALL be high when h_cnt=0.
REQ-028 In SCAN, frame_start SHALL be high when h_cnt=0 and v_cnt=0.
REQ-029 In SCAN, active_end SHALL be high when h_cnt=0 and v_cnt=V_SYNC+V_BP+V_ACTIVE, marking the safe point for game-state update.
REQ-030 frame_cnt SHALL increment by 1 on each cycle frame_start=1, wrapping 0xFFFF->0.
REQ-031 HSYNC, VSYNC and DATA_EN SHALL equal raw hsync, raw vsync and pix_act, polarity-applied, delayed through a PIPE-stage shift register; PIPE=0 SHALL be same-cycle.
REQ-032 After IDLE entry, the delay line SHALL flush naturally, so that all outputs reach inactive PIPE cycles later.

Reset
REQ-033 NRST=0 SHALL immediately set FSM=IDLE, counters=0, frame_cnt=0, strobes=0, pix_act=0, pix_x=pix_y=0, DATA_EN=0, and every delay stage and HSYNC/VSYNC to deasserted (!HS_POL / !VS_POL).
REQ-034 Reset asserted mid-frame SHALL abandon the frame; after release, scanning SHALL restart only via REQ-022.

Verification
Test parameters: H 8/2/3/2 (H_TOTAL=15), V 4/1/2/1 (V_TOTAL=8), PIPE=2, pols 0.
REQ-035 Run held 1 for 2 frames -> frame_start at cycles 1 and 121 after run, line_start every 15 cycles, frame_cnt=2, 32 pix_act cycles per frame.
REQ-036 Run held 1 -> first pix_act at h=5, v=3 with pix_x=0, pix_y=0; last pix_act at h=12, v=6 with pix_x=7, pix_y=3; DATA_EN equals pix_act 2 cycles later.
REQ-037 Raw hsync check -> HSYNC low for 3 cycles starting 2 cycles after each line_start; VSYNC low for 30 cycles per frame.
REQ-038 Run dropped at v=2 -> frame completes, busy falls after h=14, v=7, no further frame_start, outputs idle 2 cycles later.
REQ-039 NRST pulsed low at v=4, h=6 -> all outputs immediately reset values, frame_cnt=0; run=1 then restarts at h=0, v=0.
REQ-040 active_end check -> single pulse per frame at h=0, v=7; PIPE=0 build -> DATA_EN identical to pix_act.
